guess_issuer: RTL
=================

Name: guess_issuer

Overview:
- Player-side front end of the Hangman guess interface. It is the producer of the guess/go handshake that the letter-checking FSM consumes.
- Captures a 5-bit letter code from the switches when the submit key is pressed.
- Rejects codes that are not letters, and rejects letters that were already guessed.
- Issues each accepted guess to the checker with a valid/ready handshake, then waits for the hit/miss result.
- Owns the lives counter and the win/lose status.

Parameters:
- LETTER_W, 5, width of the letter code (A=0 … Z=25).
- NUM_LETTERS, 26, number of legal codes; codes >= NUM_LETTERS are invalid.
- LIVES, 6, misses allowed before loss; must fit in 3 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- letter_in  in  LETTER_W  letter code from SW[4:0]; only sampled on a submit edge.
- submit_n  in  1  raw active-low key (KEY[0]), asynchronous to clk.
- guess  out  LETTER_W  letter being issued to the checker.
- guess_valid  out  1  guess is presented; held until accepted.
- guess_ready  in  1  checker can accept a guess.
- result_valid  in  1  one-cycle strobe: the checker's verdict is ready.
- result_hit  in  1  the guess matched at least one word position.
- word_complete  in  1  all word positions are now revealed; sampled with result_valid.
- lives  out  3  remaining lives.
- game_over  out  1  the game has ended (won or lost).
- won  out  1  valid only while game_over=1.
- invalid_err  out  1  one-cycle pulse: a code >= NUM_LETTERS was submitted.
- repeat_err  out  1  one-cycle pulse: an already-used letter was submitted.

Behaviour:
- Reset values: guess=0, guess_valid=0, lives=LIVES, game_over=0, won=0, invalid_err=0, repeat_err=0, used mask=0, state=IDLE. Reset dominates every other event in the same cycle.
- Submit input path:
  - submit_n passes through a 2-flop synchronizer, then a delay flop.
  - press = delayed & ~synchronized (a 1→0 transition); exactly one press per key-down, regardless of hold time.
- State machine, IDLE:
  - On a press with letter_in >= NUM_LETTERS: pulse invalid_err and stay in IDLE.
  - On a press with used[letter_in]=1: pulse repeat_err and stay in IDLE.
  - On any other press: set used[letter_in], register guess=letter_in, go to ISSUE.
- State machine, ISSUE:
  - guess_valid=1 and guess is held stable.
  - A transfer occurs on the cycle where guess_valid and guess_ready are both high. Next state is WAIT_RESULT, and guess_valid=0 from the following cycle.
- State machine, WAIT_RESULT:
  - On result_valid with result_hit=1 and word_complete=1: set won=1 and go to OVER.
  - On result_valid with result_hit=1 and word_complete=0: go to IDLE.
  - On result_valid with result_hit=0: lives decrements. If the new value is 0, go to OVER with won=0; otherwise go to IDLE.
- State machine, OVER: game_over=1; all presses are ignored until reset.
- Latency: guess_valid is first high 3 clk edges after the rising edge at which submit_n is first sampled low. If guess_ready is already high, the transfer happens in that same cycle.
- Boundary conditions:
  - Presses in ISSUE, WAIT_RESULT or OVER are dropped, not queued, and cause no error pulse.
  - result_valid outside WAIT_RESULT is ignored.
  - guess_ready while guess_valid=0 is ignored.
  - lives never underflows: the decrement only happens from a nonzero value.
  - A press in the same cycle as reset is lost.
  - Reset during ISSUE drops guess_valid on the next edge with no transfer.
  - Error pulses never overlap; at most one fires per press.

Optional Feature:
- Macro: REPEAT_CHECK_EN.
- Defined: the 26-bit used mask is implemented and repeat_err behaves as above.
- Undefined: no mask is built, repeat_err is tied to 0, and repeated letters are issued normally (a repeated miss costs a life).

Decomposition:
- hangman_pkg (shared package):
  - LETTER_W, NUM_LETTERS, LIVES_DEFAULT.
  - Letter code constants LTR_A=0 … LTR_Z=25, LTR_NONE=31 (unused-position marker).
  - State enumeration IDLE/ISSUE/WAIT_RESULT/OVER, encoded in 2 bits.
- One sub-module, key_sync_edge: 2-flop synchronizer plus falling-edge detect. It is reusable for other KEY inputs.

Test Plan:
- Reset; letter_in=5'd18 (S); press submit_n for 10 cycles, then release → exactly one transfer with guess=18; after result_valid with hit=1, word_complete=0: lives=6, state IDLE.
- Press letter_in=5'd27 → invalid_err high for 1 cycle; no guess_valid; lives=6.
- Guess 18 again after it was accepted → repeat_err for 1 cycle, no transfer. Without REPEAT_CHECK_EN: a transfer with guess=18 and repeat_err=0.
- Hold guess_ready=0 for 5 cycles after guess_valid rises → guess_valid and guess stay stable; the transfer happens on the first cycle guess_ready=1.
- Six guesses of distinct letters, each answered result_hit=0 → lives steps 5,4,3,2,1,0; after the sixth result, game_over=1 and won=0. A further press gives no guess_valid.
- Guesses 18, 19, 0, 24 with hits, word_complete=1 on the last result → game_over=1, won=1, lives=6. Assert reset mid-ISSUE on a separate run → guess_valid=0 on the next edge, lives=6, used mask cleared.

Source files
------------

// File: rtl/hangman_pkg.sv
// Shared Hangman definitions: letter-code width and count, default lives,
// letter code constants and the guess issuer state encoding.
package hangman_pkg;
  localparam int LETTER_W      = 5;
  localparam int NUM_LETTERS   = 26;
  localparam int LIVES_DEFAULT = 6;

  localparam logic [LETTER_W-1:0] LTR_A = 5'd0,  LTR_B = 5'd1,  LTR_C = 5'd2,  LTR_D = 5'd3;
  localparam logic [LETTER_W-1:0] LTR_E = 5'd4,  LTR_F = 5'd5,  LTR_G = 5'd6,  LTR_H = 5'd7;
  localparam logic [LETTER_W-1:0] LTR_I = 5'd8,  LTR_J = 5'd9,  LTR_K = 5'd10, LTR_L = 5'd11;
  localparam logic [LETTER_W-1:0] LTR_M = 5'd12, LTR_N = 5'd13, LTR_O = 5'd14, LTR_P = 5'd15;
  localparam logic [LETTER_W-1:0] LTR_Q = 5'd16, LTR_R = 5'd17, LTR_S = 5'd18, LTR_T = 5'd19;
  localparam logic [LETTER_W-1:0] LTR_U = 5'd20, LTR_V = 5'd21, LTR_W = 5'd22, LTR_X = 5'd23;
  localparam logic [LETTER_W-1:0] LTR_Y = 5'd24, LTR_Z = 5'd25;
  // Marks a word position that holds no letter.
  localparam logic [LETTER_W-1:0] LTR_NONE = 5'd31;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, OVER} state_t;
endpackage

// File: rtl/key_sync_edge.sv
// Synchronizes a raw active-low key into clk and emits a one-cycle press
// pulse on each key-down (1->0), however long the key is held.
// Ports: clk, reset (sync, active high), key_n (raw key), press (pulse).
module key_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  logic s1, s2, dly;

  // Reset to the released level so leaving reset never fakes an edge.
  // press is registered, giving a clean glitch-free pulse to the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      dly   <= 1'b1;
      press <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      dly   <= s2;
      press <= dly & ~s2;
    end
  end
endmodule

// File: rtl/guess_issuer.sv
// Hangman player-side guess front end. Captures a letter on each submit key
// press, filters invalid (and optionally repeated) letters, issues the guess
// to the checker over a valid/ready handshake, then consumes the hit/miss
// verdict to maintain lives and win/lose status.
// Ports: clk, reset (sync, active high), letter_in, submit_n (raw key),
//   guess/guess_valid/guess_ready (issue handshake), result_valid/result_hit/
//   word_complete (verdict), lives, game_over, won, invalid_err, repeat_err.
// Build option: define REPEAT_CHECK_EN to track used letters and reject
//   repeats with repeat_err; otherwise repeats are issued like any guess.
module guess_issuer #(
  parameter int LETTER_W    = hangman_pkg::LETTER_W,
  parameter int NUM_LETTERS = hangman_pkg::NUM_LETTERS,
  parameter int LIVES       = hangman_pkg::LIVES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LETTER_W-1:0] letter_in,
  input  logic                submit_n,
  output logic [LETTER_W-1:0] guess,
  output logic                guess_valid,
  input  logic                guess_ready,
  input  logic                result_valid,
  input  logic                result_hit,
  input  logic                word_complete,
  output logic [2:0]          lives,
  output logic                game_over,
  output logic                won,
  output logic                invalid_err,
  output logic                repeat_err
);
  import hangman_pkg::*;

  localparam logic [LETTER_W-1:0] CODE_LIMIT = LETTER_W'(NUM_LETTERS);
  localparam logic [2:0]          LIVES_INIT = 3'(LIVES);

  state_t state, state_n;
  logic   press, take, inv_n;

  key_sync_edge u_submit (
    .clk   (clk),
    .reset (reset),
    .key_n (submit_n),
    .press (press)
  );

`ifdef REPEAT_CHECK_EN
  logic [NUM_LETTERS-1:0] used;
  logic                   rep_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    inv_n   = 1'b0;
`ifdef REPEAT_CHECK_EN
    rep_n   = 1'b0;
`endif
    unique case (state)
      IDLE: if (press) begin
        if (letter_in >= CODE_LIMIT) inv_n = 1'b1;
`ifdef REPEAT_CHECK_EN
        else if (used[letter_in])    rep_n = 1'b1;
`endif
        else begin
          take    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: if (guess_ready) state_n = WAIT_RESULT;
      WAIT_RESULT: if (result_valid) begin
        if (result_hit) state_n = word_complete ? OVER : IDLE;
        // lives is pre-decrement here: 1 means this miss is the last.
        else            state_n = (lives <= 3'd1) ? OVER : IDLE;
      end
      OVER: state_n = OVER;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      guess       <= '0;
      lives       <= LIVES_INIT;
      won         <= 1'b0;
      invalid_err <= 1'b0;
    end else begin
      invalid_err <= inv_n;
      if (take) guess <= letter_in;
      if (state == WAIT_RESULT && result_valid) begin
        if (result_hit && word_complete)    won   <= 1'b1;
        if (!result_hit && lives != 3'd0)   lives <= lives - 3'd1;
      end
    end
  end

`ifdef REPEAT_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      used       <= '0;
      repeat_err <= 1'b0;
    end else begin
      repeat_err <= rep_n;
      if (take) used[letter_in] <= 1'b1;
    end
  end
`else
  assign repeat_err = 1'b0;
`endif

  assign guess_valid = (state == ISSUE);
  assign game_over   = (state == OVER);
endmodule
